// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit                                                                 |
// | Instruction fetch stage: PC, memory handshake, redirect, misalign, halt.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'b0000_1000_0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall_fetch,
  input  logic        halt_req,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  output logic [15:0] instruction,
  output logic [15:0] incremented_pc,
  output logic        inst_stall,
  output logic        inst_mis_align,
  output logic        halted
);

  localparam logic [15:0] C_PC_STEP = 16'd2;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_WAIT     = 2'd1,
    S_MISALIGN = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic        r_pend;
  logic        w_pend_nxt;
  logic [15:0] r_pend_pc;
  logic [15:0] w_pend_pc_nxt;
  logic        r_halt_pend;
  logic        w_halt_pend_nxt;

  logic [15:0] w_pc_inc;
  logic        w_halt_any;
  logic        w_redir_take;
  logic        w_rd;
  logic        w_stall;
  logic        w_mis;

  assign w_pc_inc     = r_pc + C_PC_STEP;
  // While a read is outstanding a resolved halt masks any later redirect.
  assign w_halt_any   = halt_req | r_halt_pend;
  assign w_redir_take = redirect & ~w_halt_any;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_pend_nxt      = r_pend;
    w_pend_pc_nxt   = r_pend_pc;
    w_halt_pend_nxt = r_halt_pend;
    w_rd            = 1'b0;
    w_stall         = 1'b1;
    w_mis           = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (halt_req) begin
          w_state_nxt = S_HALTED;
        end else if (r_pc[0]) begin
          if (redirect) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_mis       = 1'b1;
            w_stall     = 1'b0;
            w_state_nxt = S_MISALIGN;
          end
        end else begin
          w_rd = 1'b1;
          if (redirect) begin
            w_pc_nxt = redirect_pc;
          end else if (imem_done) begin
            w_stall = 1'b0;
            if (!stall_fetch) begin
              w_pc_nxt = w_pc_inc;
            end
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        w_rd = 1'b1;
        if (imem_done) begin
          w_state_nxt     = w_halt_any ? S_HALTED : S_FETCH;
          w_pend_nxt      = 1'b0;
          w_halt_pend_nxt = 1'b0;
          // A redirect seen during the wait makes the returning word stale.
          if (w_redir_take) begin
            w_pc_nxt = redirect_pc;
          end else if (r_pend) begin
            w_pc_nxt = r_pend_pc;
          end else begin
            w_stall = 1'b0;
            if (!stall_fetch) begin
              w_pc_nxt = w_pc_inc;
            end
          end
        end else begin
          if (halt_req) begin
            w_halt_pend_nxt = 1'b1;
          end
          if (w_redir_take) begin
            w_pend_nxt    = 1'b1;
            w_pend_pc_nxt = redirect_pc;
          end
        end
      end

      S_MISALIGN: begin
        if (halt_req) begin
          w_state_nxt = S_HALTED;
        end else if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = S_FETCH;
        end
      end

      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_pend      <= 1'b0;
      r_pend_pc   <= RESET_PC;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_pc   <= w_pend_pc_nxt;
      r_halt_pend <= w_halt_pend_nxt;
    end
  end

  // Outputs follow the reset pin directly so they are quiet while it is held.
  assign imem_addr      = r_pc;
  assign incremented_pc = w_pc_inc;
  assign imem_rd        = rst & w_rd;
  assign inst_stall     = ~rst | w_stall;
  assign inst_mis_align = rst & w_mis;
  assign halted         = rst & (r_state == S_HALTED);
  assign instruction    = (inst_stall | inst_mis_align) ? NOP_INST : imem_data;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_unit                                                              |
// | Directed scenarios plus randomized traffic against a behavioural model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [15:0] C_NOP = 16'b0000_1000_0000_0000;
  localparam int MD_RUN  = 0;
  localparam int MD_WAIT = 1;
  localparam int MD_TRAP = 2;
  localparam int MD_STOP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        stall_fetch = 1'b0;
  logic        halt_req = 1'b0;
  logic [15:0] imem_data = 16'h0;
  logic        imem_done = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] instruction;
  logic [15:0] incremented_pc;
  logic        inst_stall;
  logic        inst_mis_align;
  logic        halted;

  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall_fetch(stall_fetch), .halt_req(halt_req), .imem_data(imem_data),
    .imem_done(imem_done), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .instruction(instruction), .incremented_pc(incremented_pc),
    .inst_stall(inst_stall), .inst_mis_align(inst_mis_align), .halted(halted)
  );

  always #5 clk = ~clk;

  // Behavioural reference: where fetch stands, what it will do next.
  logic [15:0] m_pc;
  int          m_mode;
  logic        m_rpend;
  logic [15:0] m_tgt;
  logic        m_hpend;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc <= 16'h0000; m_mode <= MD_RUN; m_rpend <= 1'b0; m_tgt <= 16'h0; m_hpend <= 1'b0;
    end else begin
      case (m_mode)
        MD_RUN: begin
          if (halt_req) m_mode <= MD_STOP;
          else if (redirect) m_pc <= redirect_pc;
          else if (m_pc[0]) m_mode <= MD_TRAP;
          else if (imem_done) m_pc <= stall_fetch ? m_pc : m_pc + 16'd2;
          else m_mode <= MD_WAIT;
        end
        MD_WAIT: begin
          if (imem_done) begin
            if (redirect && !(halt_req || m_hpend)) m_pc <= redirect_pc;
            else if (m_rpend) m_pc <= m_tgt;
            else m_pc <= stall_fetch ? m_pc : m_pc + 16'd2;
            m_mode  <= (halt_req || m_hpend) ? MD_STOP : MD_RUN;
            m_rpend <= 1'b0;
            m_hpend <= 1'b0;
          end else if (halt_req) begin
            m_hpend <= 1'b1;
          end else if (redirect && !m_hpend) begin
            m_rpend <= 1'b1;
            m_tgt   <= redirect_pc;
          end
        end
        MD_TRAP: begin
          if (halt_req) m_mode <= MD_STOP;
          else if (redirect) begin m_pc <= redirect_pc; m_mode <= MD_RUN; end
        end
        default: m_mode <= MD_STOP;
      endcase
    end
  end

  function automatic void model_out(output logic e_rd, output logic e_stall,
                                    output logic e_mis, output logic e_halt,
                                    output logic [15:0] e_inst);
    e_rd = 1'b0; e_stall = 1'b1; e_mis = 1'b0; e_halt = 1'b0;
    if (rst) begin
      case (m_mode)
        MD_RUN: begin
          if (!halt_req) begin
            if (redirect) e_rd = ~m_pc[0];
            else if (m_pc[0]) begin e_mis = 1'b1; e_stall = 1'b0; end
            else begin e_rd = 1'b1; e_stall = ~imem_done; end
          end
        end
        MD_WAIT: begin
          e_rd = 1'b1;
          e_stall = !(imem_done && !m_rpend && !(redirect && !(halt_req || m_hpend)));
        end
        MD_STOP: e_halt = 1'b1;
        default: ;
      endcase
    end
    e_inst = (e_stall || e_mis) ? C_NOP : imem_data;
  endfunction

  task automatic drive(input logic rd_v, input logic [15:0] rpc, input logic st,
                       input logic hl, input logic dn, input logic [15:0] dat);
    @(negedge clk);
    rst = 1'b1; redirect = rd_v; redirect_pc = rpc; stall_fetch = st;
    halt_req = hl; imem_done = dn; imem_data = dat;
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b0; imem_data = 16'hBEEF; imem_done = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL reset_rd: got %b expected 0", imem_rd); end
    checks++; if (inst_stall !== 1'b1) begin failures++; $display("FAIL reset_stall: got %b expected 1", inst_stall); end
    checks++; if (inst_mis_align !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL reset_flags: got mis=%b halted=%b expected 0 0", inst_mis_align, halted); end
    checks++; if (instruction !== C_NOP) begin failures++; $display("FAIL reset_inst: got %h expected %h", instruction, C_NOP); end
    checks++; if (imem_addr !== 16'h0000 || incremented_pc !== 16'h0002) begin failures++; $display("FAIL reset_pc: got addr=%h inc=%h expected 0000 0002", imem_addr, incremented_pc); end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1000 + 16'(i));
      checks++; if (imem_addr !== 16'(2 * i)) begin failures++; $display("FAIL seq_addr: got %h expected %h", imem_addr, 16'(2 * i)); end
      checks++; if (inst_stall !== 1'b0 || instruction !== 16'h1000 + 16'(i)) begin failures++; $display("FAIL seq_inst: got stall=%b inst=%h expected 0 %h", inst_stall, instruction, 16'h1000 + 16'(i)); end
    end
  endtask

  task automatic test_wait;
    drive(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h5555);
      checks++; if (inst_stall !== 1'b1 || imem_addr !== 16'h0010 || imem_rd !== 1'b1) begin failures++; $display("FAIL wait_hold: got stall=%b addr=%h rd=%b expected 1 0010 1", inst_stall, imem_addr, imem_rd); end
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hA5A5);
    checks++; if (inst_stall !== 1'b0 || instruction !== 16'hA5A5) begin failures++; $display("FAIL wait_deliver: got stall=%b inst=%h expected 0 a5a5", inst_stall, instruction); end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0);
    checks++; if (imem_addr !== 16'h0012) begin failures++; $display("FAIL wait_next: got %h expected 0012", imem_addr); end
  endtask

  task automatic test_redirect_wait;
    drive(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0);
    checks++; if (inst_stall !== 1'b1 || imem_addr !== 16'h0020) begin failures++; $display("FAIL rw_hold: got stall=%b addr=%h expected 1 0020", inst_stall, imem_addr); end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h7777);
    checks++; if (inst_stall !== 1'b1 || instruction !== C_NOP) begin failures++; $display("FAIL rw_discard: got stall=%b inst=%h expected 1 %h", inst_stall, instruction, C_NOP); end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0);
    checks++; if (imem_addr !== 16'h0100) begin failures++; $display("FAIL rw_target: got %h expected 0100", imem_addr); end
  endtask

  task automatic test_misalign;
    drive(1'b1, 16'h0031, 1'b0, 1'b0, 1'b1, 16'h0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1234);
    checks++; if (inst_mis_align !== 1'b1 || imem_rd !== 1'b0 || inst_stall !== 1'b0 || instruction !== C_NOP) begin failures++; $display("FAIL mis_flag: got mis=%b rd=%b stall=%b inst=%h expected 1 0 0 %h", inst_mis_align, imem_rd, inst_stall, instruction, C_NOP); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1234);
      checks++; if (inst_mis_align !== 1'b0 || inst_stall !== 1'b1 || imem_rd !== 1'b0 || imem_addr !== 16'h0031) begin failures++; $display("FAIL mis_hold: got mis=%b stall=%b rd=%b addr=%h expected 0 1 0 0031", inst_mis_align, inst_stall, imem_rd, imem_addr); end
    end
    drive(1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 16'h0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h4444);
    checks++; if (imem_addr !== 16'h0040 || imem_rd !== 1'b1 || inst_stall !== 1'b0) begin failures++; $display("FAIL mis_resume: got addr=%h rd=%b stall=%b expected 0040 1 0", imem_addr, imem_rd, inst_stall); end
  endtask

  task automatic test_halt;
    drive(1'b1, 16'h0050, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'($urandom) & 16'hFFFE, 1'b1, 1'b0, 1'b1, 16'h0);
      checks++; if (halted !== 1'b1 || imem_rd !== 1'b0 || inst_stall !== 1'b1 || imem_addr !== 16'h0050) begin failures++; $display("FAIL halt_hold: got halted=%b rd=%b stall=%b addr=%h expected 1 0 1 0050", halted, imem_rd, inst_stall, imem_addr); end
    end
    rst = 1'b0; #1;
    checks++; if (halted !== 1'b0 || imem_addr !== 16'h0000 || imem_rd !== 1'b0) begin failures++; $display("FAIL halt_reset: got halted=%b addr=%h rd=%b expected 0 0000 0", halted, imem_addr, imem_rd); end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h2222);
    checks++; if (imem_addr !== 16'h0000 || imem_rd !== 1'b1 || inst_stall !== 1'b0) begin failures++; $display("FAIL halt_restart: got addr=%h rd=%b stall=%b expected 0000 1 0", imem_addr, imem_rd, inst_stall); end
  endtask

  task automatic test_reset_wait;
    drive(1'b1, 16'h0060, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    rst = 1'b0; #1;
    checks++; if (imem_addr !== 16'h0000 || inst_stall !== 1'b1 || imem_rd !== 1'b0) begin failures++; $display("FAIL rstw_abort: got addr=%h stall=%b rd=%b expected 0000 1 0", imem_addr, inst_stall, imem_rd); end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h3333);
    checks++; if (imem_addr !== 16'h0000 || inst_stall !== 1'b0 || instruction !== 16'h3333) begin failures++; $display("FAIL rstw_first: got addr=%h stall=%b inst=%h expected 0000 0 3333", imem_addr, inst_stall, instruction); end
  endtask

  task automatic test_wrap;
    drive(1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h6666);
    checks++; if (incremented_pc !== 16'h0000 || inst_stall !== 1'b0 || imem_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_inc: got inc=%h stall=%b addr=%h expected 0000 0 fffe", incremented_pc, inst_stall, imem_addr); end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_next: got %h expected 0000", imem_addr); end
  endtask

  task automatic test_random;
    logic e_rd, e_stall, e_mis, e_halt;
    logic [15:0] e_inst;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst         = !($urandom_range(0, 199) == 0 || (m_mode == MD_STOP && $urandom_range(0, 7) == 0));
      redirect    = ($urandom_range(0, 5) == 0);
      redirect_pc = 16'($urandom);
      if ($urandom_range(0, 7) != 0) redirect_pc[0] = 1'b0;
      stall_fetch = ($urandom_range(0, 3) == 0);
      halt_req    = ($urandom_range(0, 59) == 0);
      imem_done   = ($urandom_range(0, 1) == 0);
      imem_data   = 16'($urandom);
      #2;
      model_out(e_rd, e_stall, e_mis, e_halt, e_inst);
      checks++; if (imem_rd !== e_rd) begin failures++; $display("FAIL rnd_rd: cycle %0d got %b expected %b", i, imem_rd, e_rd); end
      checks++; if (inst_stall !== e_stall) begin failures++; $display("FAIL rnd_stall: cycle %0d got %b expected %b", i, inst_stall, e_stall); end
      checks++; if (inst_mis_align !== e_mis) begin failures++; $display("FAIL rnd_mis: cycle %0d got %b expected %b", i, inst_mis_align, e_mis); end
      checks++; if (halted !== e_halt) begin failures++; $display("FAIL rnd_halted: cycle %0d got %b expected %b", i, halted, e_halt); end
      checks++; if (instruction !== e_inst) begin failures++; $display("FAIL rnd_inst: cycle %0d got %h expected %h", i, instruction, e_inst); end
      checks++; if (imem_addr !== m_pc) begin failures++; $display("FAIL rnd_addr: cycle %0d got %h expected %h", i, imem_addr, m_pc); end
      checks++; if (incremented_pc !== m_pc + 16'd2) begin failures++; $display("FAIL rnd_inc: cycle %0d got %h expected %h", i, incremented_pc, m_pc + 16'd2); end
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset;
    test_sequential;
    test_wait;
    test_redirect_wait;
    test_misalign;
    test_halt;
    test_reset_wait;
    test_wrap;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
